// File: rtl/shift_issue_queue.sv
// Shift/rotate issue queue: operand FIFO, barrel shifter, registered result stage.
// Optional SHIFT_ZERO_FLAG_EN adds a registered out_zero flag beside out_data.
module barrelShifter #(
  parameter int N = 16,
  parameter int C = 4,
  parameter int O = 2
) (
  input  logic [N-1:0] data,
  input  logic [C-1:0] cnt,
  input  logic [O-1:0] op,
  input  logic         btr,
  output logic [N-1:0] res
);
  logic [2*N-1:0] dbl_l;
  logic [2*N-1:0] dbl_r;
  logic [N-1:0]   rev;

  always_comb begin
    dbl_l = {data, data} << cnt;
    dbl_r = {data, data} >> cnt;
    rev   = '0;
    for (int i = 0; i < N; i++) begin
      rev[i] = data[N-1-i];
    end
  end

  always_comb begin
    res = data;
    if (btr) begin
      res = rev;
    end else begin
      unique case (op)
        2'b00: res = dbl_l[2*N-1:N];
        2'b01: res = data << cnt;
        2'b10: res = dbl_r[N-1:0];
        2'b11: res = data >> cnt;
        default: res = data;
      endcase
    end
  end
endmodule

module shift_issue_queue #(
  parameter int N     = 16,
  parameter int C     = 4,
  parameter int O     = 2,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [C-1:0] in_cnt,
  input  logic [O-1:0] in_op,
  input  logic         in_btr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
`ifdef SHIFT_ZERO_FLAG_EN
  output logic         out_zero,
`endif
  output logic         busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [N-1:0] data;
    logic [C-1:0] cnt;
    logic [O-1:0] op;
    logic         btr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  entry_t        head;
  logic [N-1:0]  res;
  logic          push;
  logic          pop;

  assign in_ready = (count < CW'(DEPTH));
  assign busy     = (count != '0) | out_valid;
  assign push     = in_valid & in_ready;
  assign pop      = (count != '0) & (~out_valid | out_ready);
  assign head     = mem[rptr];

  barrelShifter #(.N(N), .C(C), .O(O)) u_shift (
    .data (head.data),
    .cnt  (head.cnt),
    .op   (head.op),
    .btr  (head.btr),
    .res  (res)
  );

  // Storage needs no reset; pointers and count decide what is live.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wptr] <= '{data: in_data, cnt: in_cnt, op: in_op, btr: in_btr};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef SHIFT_ZERO_FLAG_EN
      out_zero  <= 1'b0;
`endif
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
`ifdef SHIFT_ZERO_FLAG_EN
      out_zero  <= 1'b0;
`endif
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr      <= rptr + 1'b1;
        out_valid <= 1'b1;
        out_data  <= res;
`ifdef SHIFT_ZERO_FLAG_EN
        out_zero  <= (res == '0);
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_issue_queue.sv
// Directed testbench for shift_issue_queue.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_shift_issue_queue;
  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_cnt;
  logic [1:0]  in_op;
  logic        in_btr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;
`ifdef SHIFT_ZERO_FLAG_EN
  logic        out_zero;
`endif

  int errs;
  int checks;

  shift_issue_queue dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_op     (in_op),
    .in_btr    (in_btr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef SHIFT_ZERO_FLAG_EN
    .out_zero  (out_zero),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] d, input logic [3:0] c,
                       input logic [1:0] o, input logic b);
    in_valid = 1'b1;
    in_data  = d;
    in_cnt   = c;
    in_op    = o;
    in_btr   = b;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_data  = '0;
    in_cnt   = '0;
    in_op    = '0;
    in_btr   = 1'b0;
  endtask

  // Single request with output free: accept, then result one edge later.
  task automatic single(input string tag, input logic [15:0] d,
                        input logic [3:0] c, input logic [1:0] o,
                        input logic b, input logic [15:0] exp);
    drive(d, c, o, b);
    @(negedge clk);
    idle_in();
    chk({tag, "_pre"}, out_valid, 0);
    @(negedge clk);
    chk({tag, "_vld"}, out_valid, 1);
    chk(tag, out_data, exp);
    @(negedge clk);
    chk({tag, "_drop"}, out_valid, 0);
  endtask

  logic [15:0] bb_d [3];
  logic [3:0]  bb_c [3];
  logic [1:0]  bb_o [3];
  logic [15:0] bb_e [3];

  initial begin
    errs      = 0;
    checks    = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    idle_in();
    #1;
    chk("rst_ovalid", out_valid, 0);
    chk("rst_odata", out_data, 0);
    chk("rst_iready", in_ready, 1);
    chk("rst_busy", busy, 0);
`ifdef SHIFT_ZERO_FLAG_EN
    chk("rst_zero", out_zero, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    single("rol1", 16'h8001, 4'd1, 2'b00, 1'b0, 16'h0003);

    // Back-to-back stream
    bb_d = '{16'h00F0, 16'h8000, 16'h0001};
    bb_c = '{4'd4, 4'd15, 4'd1};
    bb_o = '{2'b01, 2'b11, 2'b10};
    bb_e = '{16'h0F00, 16'h0001, 16'h8000};
    for (int i = 0; i < 3; i++) begin
      drive(bb_d[i], bb_c[i], bb_o[i], 1'b0);
      @(negedge clk);
      chk("bb_iready", in_ready, 1);
      if (i > 0) begin
        chk("bb_vld", out_valid, 1);
        chk("bb_data", out_data, bb_e[i-1]);
      end
    end
    idle_in();
    @(negedge clk);
    chk("bb_vld", out_valid, 1);
    chk("bb_data", out_data, bb_e[2]);
    @(negedge clk);
    chk("bb_end_vld", out_valid, 0);
    chk("bb_end_busy", busy, 0);

    // Stalled output, four pushes
    out_ready = 1'b0;
    drive(16'h1234, 4'd4, 2'b00, 1'b0);
    @(negedge clk);
    drive(16'h00FF, 4'd8, 2'b01, 1'b0);
    @(negedge clk);
    chk("st_vld", out_valid, 1);
    chk("st_d0", out_data, 16'h2341);
    drive(16'hF000, 4'd12, 2'b11, 1'b0);
    @(negedge clk);
    chk("st_full", in_ready, 0);
    drive(16'h00AA, 4'd0, 2'b10, 1'b0);
    @(negedge clk);
    chk("st_full2", in_ready, 0);
    chk("st_hold", out_data, 16'h2341);
    idle_in();
    @(negedge clk);
    chk("st_hold2", out_data, 16'h2341);
    chk("st_busy", busy, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("st_d1", out_data, 16'hFF00);
    chk("st_ir", in_ready, 1);
    @(negedge clk);
    chk("st_d2_vld", out_valid, 1);
    chk("st_d2", out_data, 16'h000F);
    @(negedge clk);
    chk("st_no4th", out_valid, 0);
    chk("st_idle", busy, 0);

    single("btr", 16'h0001, 4'd3, 2'b01, 1'b1, 16'h8000);
    single("btr2", 16'h1234, 4'd7, 2'b00, 1'b1, 16'h2C48);
    single("ror0", 16'hABCD, 4'd0, 2'b10, 1'b0, 16'hABCD);
    single("srl0", 16'hABCD, 4'd0, 2'b11, 1'b0, 16'hABCD);
    single("rol15", 16'h0001, 4'd15, 2'b00, 1'b0, 16'h8000);

    // Flush with work queued and a push in the same cycle
    out_ready = 1'b0;
    drive(16'h0011, 4'd1, 2'b01, 1'b0);
    @(negedge clk);
    drive(16'h0022, 4'd1, 2'b01, 1'b0);
    @(negedge clk);
    drive(16'h0033, 4'd1, 2'b01, 1'b0);
    @(negedge clk);
    chk("fl_pre_busy", busy, 1);
    drive(16'h0044, 4'd1, 2'b01, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    idle_in();
    chk("fl_vld", out_valid, 0);
    chk("fl_busy", busy, 0);
    chk("fl_ir", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fl_stale", out_valid, 0);
    end

    // Async reset between edges mid-drain
    out_ready = 1'b0;
    drive(16'h0101, 4'd2, 2'b01, 1'b0);
    @(negedge clk);
    drive(16'h0202, 4'd2, 2'b01, 1'b0);
    @(negedge clk);
    idle_in();
    chk("ar_pre", out_data, 16'h0404);
    out_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("ar_vld", out_valid, 0);
    chk("ar_data", out_data, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ir", in_ready, 1);
    @(negedge clk);
    chk("ar_hold", out_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("ar_after", out_valid, 0);

`ifdef SHIFT_ZERO_FLAG_EN
    single("zf_sll", 16'h8000, 4'd1, 2'b01, 1'b0, 16'h0000);
    drive(16'h8000, 4'd1, 2'b01, 1'b0);
    @(negedge clk);
    idle_in();
    @(negedge clk);
    chk("zf_one", out_zero, 1);
    @(negedge clk);
    drive(16'h4000, 4'd1, 2'b01, 1'b0);
    @(negedge clk);
    idle_in();
    @(negedge clk);
    chk("zf_zero", out_zero, 0);
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
